// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types and constants for the 5-stage pipeline stall and
//               flush sequencer. It holds the controller state enumeration and
//               the register-index width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  // Width of an architectural register index (rs / rt fields)
  localparam int REG_IDX_W = 5;

  // Controller states:
  //   ST_RUN   - normal operation; hazards are resolved in the same cycle
  //   ST_DWAIT - waiting for the data memory to acknowledge an access
  //   ST_HALT  - the watchdog expired; only reset leaves this state
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage : pipeline_ctrl_pkg

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard comparator. It flags a hazard
//               when the instruction in EX is a load whose destination (which
//               is not r0) matches either source register of the instruction
//               in ID.
// Ports       : idex_memread_i - EX instruction is a load
//               idex_rt_i      - load destination register
//               ifid_rs_i      - ID source register rs
//               ifid_rt_i      - ID source register rt
//               hazard_o       - load-use hazard present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rt_i,
  input  logic [REG_IDX_W-1:0] ifid_rs_i,
  input  logic [REG_IDX_W-1:0] ifid_rt_i,
  output logic                 hazard_o
);

  logic dst_nonzero;
  logic src_match;

  // r0 is hard-wired to zero, so a load into r0 never creates a dependency
  assign dst_nonzero = (idex_rt_i != '0);
  assign src_match   = (idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i);
  assign hazard_o    = idex_memread_i && dst_nonzero && src_match;

endmodule : hazard_detect

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central stall/flush sequencer for a 5-stage pipeline. It
//               drives the PC and pipeline-register write enables plus the
//               IF/ID flush and ID/EX bubble controls. It also runs the
//               data-memory request handshake, a memory watchdog and
//               saturating stall and flush performance counters.
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               idex_memread_i/rt_i   - load in EX and its destination
//               ifid_rs_i/rt_i        - sources of the instruction in ID
//               branch_taken_i        - ID-stage branch resolved taken
//               dmem_req_i/ack_i      - MEM-stage access request / completion
//               *_we_o                - PC and pipeline-register enables
//               ifid_flush_o          - load a NOP into IF/ID
//               idex_bubble_o         - load a NOP into ID/EX
//               dmem_valid_o          - request to data memory
//               stall_cnt_o           - stall cycles (saturating)
//               flush_cnt_o           - branch flushes (saturating)
//               timeout_o             - sticky watchdog error
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rt_i,
  input  logic [REG_IDX_W-1:0] ifid_rs_i,
  input  logic [REG_IDX_W-1:0] ifid_rt_i,
  input  logic                 branch_taken_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ack_i,
  output logic                 pc_we_o,
  output logic                 ifid_we_o,
  output logic                 idex_we_o,
  output logic                 exmem_we_o,
  output logic                 memwb_we_o,
  output logic                 ifid_flush_o,
  output logic                 idex_bubble_o,
  output logic                 dmem_valid_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o,
  output logic                 timeout_o
);

  // The watchdog count only needs to reach TIMEOUT_CYC-1
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The RUN cycle that raises the stall counts as the first stall cycle, so
  // the last DWAIT cycle tolerated without ack is the one holding
  // TIMEOUT_CYC-2. Its increment would bring the count to TIMEOUT_CYC-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             timeout_q, timeout_d;

  logic load_use;
  logic advance;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_bubble, dmem_valid;

  hazard_detect u_hazard_detect (
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .hazard_o       (load_use)
  );

  // --------------------------------------------------------------------------
  // Next-state and stage-control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    timeout_d   = timeout_q;
    advance     = 1'b0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    dmem_valid  = 1'b0;

    case (state_q)
      ST_RUN: begin
        // An ack without a request is ignored
        dmem_valid = dmem_req_i;
        if (dmem_req_i && !dmem_ack_i) begin
          state_d = ST_DWAIT;
          wd_d    = '0;
        end else begin
          advance = 1'b1;
        end
      end
      ST_DWAIT: begin
        dmem_valid = 1'b1;
        if (dmem_ack_i) begin
          advance = 1'b1;
          state_d = ST_RUN;
        end else if (wd_q == WD_LAST) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // When the memory side lets the pipeline move, load-use beats branch.
    // A frozen ID keeps the branch alive, so the branch is flushed next cycle.
    if (advance) begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      memwb_we = 1'b1;
      if (load_use) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end else if (branch_taken_i) begin
        ifid_flush = 1'b1;
      end
    end

    // Reset silences every control, which also abandons an in-flight access
    if (rst_i) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      dmem_valid  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != ST_HALT) && !pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pc_we_o       = pc_we;
  assign ifid_we_o     = ifid_we;
  assign idex_we_o     = idex_we;
  assign exmem_we_o    = exmem_we;
  assign memwb_we_o    = memwb_we;
  assign ifid_flush_o  = ifid_flush;
  assign idex_bubble_o = idex_bubble;
  assign dmem_valid_o  = dmem_valid;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign timeout_o     = timeout_q;

endmodule : pipeline_ctrl

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Scoreboard testbench for pipeline_ctrl. Each applied cycle
//               pushes the reference model's expected outputs into a queue.
//               A negedge monitor pops the queue and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  localparam int TO      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          idex_memread_i;
  logic [4:0]    idex_rt_i, ifid_rs_i, ifid_rt_i;
  logic          branch_taken_i, dmem_req_i, dmem_ack_i;
  logic          pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o;
  logic          ifid_flush_o, idex_bubble_o, dmem_valid_o, timeout_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .pc_we_o        (pc_we_o),
    .ifid_we_o      (ifid_we_o),
    .idex_we_o      (idex_we_o),
    .exmem_we_o     (exmem_we_o),
    .memwb_we_o     (memwb_we_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .dmem_valid_o   (dmem_valid_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .timeout_o      (timeout_o)
  );

  typedef struct {
    logic pc, ifid, idex, exmem, memwb, flush, bubble, valid, to;
    int   sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: pipeline halted?, waiting on memory?, consecutive
  // stall cycles of the current access, counters and the error flag.
  bit m_halt = 0, m_wait = 0, m_to = 0;
  int m_run = 0, m_sc = 0, m_fc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
  endtask

  // Apply one cycle of inputs and predict what the DUT must show during it
  task automatic step(input bit r, input bit mr, input int rt, input int rs,
                      input int rtd, input bit br, input bit rq, input bit ak);
    exp_t e;
    bit   lu, access, frozen;
    @(posedge clk_i); #1;
    rst_i          = r;
    idex_memread_i = mr;
    idex_rt_i      = 5'(rt);
    ifid_rs_i      = 5'(rs);
    ifid_rt_i      = 5'(rtd);
    branch_taken_i = br;
    dmem_req_i     = rq;
    dmem_ack_i     = ak;

    lu     = mr && (rt != 0) && (rt == rs || rt == rtd);
    access = m_wait || rq;
    frozen = access && !ak;
    e = '{pc: 0, ifid: 0, idex: 0, exmem: 0, memwb: 0, flush: 0, bubble: 0,
          valid: 0, to: m_to, sc: m_sc, fc: m_fc};
    if (!r && !m_halt) begin
      e.valid = access;
      if (!frozen) begin
        e.pc = 1; e.ifid = 1; e.idex = 1; e.exmem = 1; e.memwb = 1;
        if (lu) begin
          e.pc = 0; e.ifid = 0; e.bubble = 1;
        end else if (br) begin
          e.flush = 1;
        end
      end
    end
    q.push_back(e);

    if (r) begin
      m_halt = 0; m_wait = 0; m_to = 0; m_run = 0; m_sc = 0; m_fc = 0;
    end else if (!m_halt) begin
      if (!e.pc && m_sc < CNT_MAX) m_sc++;
      if (e.flush && m_fc < CNT_MAX) m_fc++;
      if (frozen) begin
        m_run++;
        if (m_run == TO) begin
          m_halt = 1; m_to = 1; m_wait = 0;
        end else begin
          m_wait = 1;
        end
      end else begin
        m_wait = 0; m_run = 0;
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_we",     pc_we_o,       e.pc);
      chk("ifid_we",   ifid_we_o,     e.ifid);
      chk("idex_we",   idex_we_o,     e.idex);
      chk("exmem_we",  exmem_we_o,    e.exmem);
      chk("memwb_we",  memwb_we_o,    e.memwb);
      chk("flush",     ifid_flush_o,  e.flush);
      chk("bubble",    idex_bubble_o, e.bubble);
      chk("dmem_vld",  dmem_valid_o,  e.valid);
      chk("timeout",   timeout_o,     e.to);
      chk("stall_cnt", 32'(stall_cnt_o), 32'(e.sc));
      chk("flush_cnt", 32'(flush_cnt_o), 32'(e.fc));
    end
  end

  initial begin
    rst_i = 1; idex_memread_i = 0; idex_rt_i = 0; ifid_rs_i = 0; ifid_rt_i = 0;
    branch_taken_i = 0; dmem_req_i = 0; dmem_ack_i = 0;
    repeat (2) @(posedge clk_i);

    // Reset cycle, then load-use on r8 followed by a load into r0
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8, 8, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Branch pulse
    step(0, 0, 0, 1, 2, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Access with ack on the fourth cycle, plus a branch held during the wait
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use and branch together
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 5, 0, 1, 0, 0);
    step(0, 0, 5, 5, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Watchdog: no ack -> HALT, then reset restores RUN
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 3, 3, 3, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Counter saturation under 20 stall cycles
    for (int i = 0; i < 20; i++) step(0, 1, 7, 0, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Abandon an access with reset mid-wait
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    end

    @(negedge clk_i); #1;
    if (q.size() != 0) chk("sb_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "time limit");
  end

endmodule : tb_pipeline_ctrl

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB). Each cycle it drives the write enables of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the flush and bubble controls, so that load-use hazards, taken branches and multi-cycle data-memory accesses are resolved in one place. It also runs the data-memory request/acknowledge handshake, a memory watchdog, and performance counters.

## Interface
- TIMEOUT_CYC, 64: DWAIT cycles without ack before the watchdog fires (≥2).
- CNT_W, 32: performance counter width.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rt_i  in  5  load destination register in EX.
- ifid_rs_i, ifid_rt_i  in  5 each  source registers of the instruction in ID.
- branch_taken_i  in  1  ID-stage branch resolved taken.
- dmem_req_i  in  1  instruction in MEM accesses data memory.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o  out  1 each  stage write enables.
- ifid_flush_o  out  1  load a NOP into IF/ID.
- idex_bubble_o  out  1  load a NOP (all control bits 0) into ID/EX.
- dmem_valid_o  out  1  request to data memory.
- stall_cnt_o  out  CNT_W  stall cycles, saturating.
- flush_cnt_o  out  CNT_W  branch flushes, saturating.
- timeout_o  out  1  sticky watchdog error.

## Operation
- FSM states: RUN, DWAIT, HALT. Reset state: RUN.
- The stage controls are combinational from the state and inputs. The counters, timeout_o and the watchdog count are registered.
- Priority in RUN is memory stall > load-use > branch.
  - **Memory stall:** dmem_req_i=1 and dmem_ack_i=0. All five *_we_o=0, dmem_valid_o=1, no flush or bubble. Next state is DWAIT.
  - **Zero-wait access:** dmem_req_i=1 and dmem_ack_i=1. Normal advance and stay in RUN.
  - **Load-use:** idex_memread_i=1, idex_rt_i≠0, and idex_rt_i equals ifid_rs_i or ifid_rt_i. pc_we_o=0, ifid_we_o=0, idex_bubble_o=1; the other enables are 1.
  - **Branch:** branch_taken_i=1 with no load-use. ifid_flush_o=1; all enables are 1.
  - **Otherwise:** all enables are 1.
  - dmem_valid_o equals dmem_req_i in RUN.
- **DWAIT:**
  - dmem_valid_o=1.
  - Without ack: all enables 0.
  - With dmem_ack_i=1: load-use and branch are evaluated as in RUN that cycle, and the next state is RUN.
- **Watchdog:**
  - The count is cleared on entry to DWAIT and increments each DWAIT cycle without ack.
  - When the count reaches TIMEOUT_CYC-1 without ack, the FSM moves to HALT and timeout_o is set to 1.
- **HALT:** all enables 0, dmem_valid_o=0, flush and bubble 0. Only rst_i leaves HALT.
- **stall_cnt_o:** +1 on each cycle in RUN or DWAIT where pc_we_o=0. Saturates at all-ones. Frozen in HALT.
- **flush_cnt_o:** +1 on each cycle where ifid_flush_o=1. Saturates at all-ones.
- **While rst_i=1:** all enables, flush, bubble and dmem_valid_o are 0. On the next edge the state is RUN and the counters, watchdog and timeout_o are 0.

## Timing
- Stall and flush decisions take effect at the same clock edge as the hazard (0-cycle latency).
- A load-use hazard costs exactly 1 bubble cycle, provided no memory stall overlaps.
- A data access with N wait cycles (ack on cycle N after the request) freezes the pipeline for N cycles and adds N to stall_cnt_o.
- Branch and load-use in the same cycle: load-use wins. ID is frozen, so the branch re-presents the next cycle and is flushed then.
- A branch during a memory stall is ignored until ack.
- dmem_ack_i outside a request (RUN with dmem_req_i=0) is ignored.
- rst_i asserted mid-DWAIT: the access is abandoned and dmem_valid_o=0 in the reset cycle.

## Structure
- Package pipeline_ctrl_pkg holds the state enum (RUN, DWAIT, HALT) and the register-index width constant (5).
- Sub-module hazard_detect holds the combinational load-use comparator (idex_memread, idex_rt, ifid_rs, ifid_rt → hazard).
- pipeline_ctrl contains the FSM, the watchdog, the counters and the output decode.

## Test plan
- Load at EX with rt=8, ID rs=8 → one cycle of pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt 0→1. With rt=0 → no stall.
- branch_taken_i pulse with no hazard → ifid_flush_o=1 for 1 cycle, enables 1; flush_cnt=1.
- dmem_req_i=1, ack after 3 cycles → exactly 3 cycles of all enables 0, then normal advance; stall_cnt=3; dmem_valid high all 4 cycles.
- Load-use and branch in the same cycle → bubble in cycle 1, flush in cycle 2; stall_cnt=1, flush_cnt=1.
- TIMEOUT_CYC=4, no ack → HALT after 4 stall cycles, timeout_o=1, all outputs 0; rst_i then restores RUN with counters 0.
- Counters with CNT_W=4 under 20 stall cycles → stall_cnt_o holds at 15.
